load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-side responder for the multicycle control state machine's load/store phase. It accepts a single-cycle request carrying the address, funct3, direction and store data, and drives a word-addressed memory port with byte enables. It waits for the memory handshake, then returns aligned and sign- or zero-extended load data with a one-cycle done pulse. It sits between the datapath (ALU result as address, rs2 as store data) and data memory, and performs the sub-word lane steering that the control unit's LS_CNTL phase relies on.

Parameters:
TIMEOUT, 15, maximum ACCESS cycles spent waiting for mem_ready before a timeout fault; legal range 1..255
ADDR_W, 32, byte-address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  1  request strobe; sampled only in IDLE
is_store  in  1  1 = store (SB/SH/SW), 0 = load
funct3  in  3  RV32I load/store width code
addr  in  ADDR_W  byte address (ALU result)
store_data  in  32  rs2 value
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_re  out  1  read strobe
mem_we  out  1  write strobe
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_rdata  in  32  read data; valid when mem_ready=1
mem_ready  in  1  memory completion
load_data  out  32  formatted load result
done  out  1  one-cycle completion pulse
misaligned  out  1  fault flag; valid with done
timeout  out  1  fault flag; valid with done
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; all outputs 0, including load_data; the wait counter is cleared. A reset during ACCESS drops mem_re and mem_we at that same edge.
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE:
  - When req=1, latch is_store, funct3, addr and store_data.
  - Raise a fault when any of these holds: an illegal funct3 (load 011/110/111; store >010); a halfword access with addr[0]=1; a word access with addr[1:0]≠00.
  - Fault → FAULT. No fault → ACCESS. The wait counter is cleared.
- ACCESS:
  - mem_re=!is_store and mem_we=is_store, both held steady until mem_ready=1 is sampled.
  - mem_addr, mem_be and mem_wdata are registered and stable throughout.
  - If mem_ready=1, go to DONE; for a load, register the formatted mem_rdata into load_data on that edge.
  - Otherwise increment the counter. When counter = TIMEOUT-1 without ready, set timeout and go to FAULT.
- DONE: done=1 for exactly one cycle, then IDLE. Strobes are 0.
- FAULT: done=1 for one cycle with misaligned or timeout set, then IDLE. load_data is unchanged; no memory strobe is issued for a misaligned fault.
- Latency: req at edge N → ACCESS during cycle N+1. If mem_ready=1 in that cycle, done is high in cycle N+2. Each wait cycle adds 1.
- req while busy=1 (including during DONE or FAULT) is ignored, never queued. mem_ready outside ACCESS is ignored.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, be=0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, be=0011<<{addr[1],0}.
  - SW: wdata=sd, be=1111.
- Loads: for LB/LBU take byte lane addr[1:0]; for LH/LHU take halfword lane addr[1]. LB and LH sign-extend, LBU and LHU zero-extend. LW passes the word through.
- load_data holds its value until the next successful load. misaligned and timeout are cleared on the next accepted req.

Decomposition:
- The shared package/include riscv_defs holds the load/store funct3 constants (L_BYTE=000, L_HWORD=001, L_WORD=010, L_BYTEU=100, L_HWORDU=101, S_BYTE=000, S_HWORD=001, S_WORD=010), the LOAD/STORE opcodes and the LSU state encodings.
- One combinational sub-module, lsu_load_format(funct3, addr[1:0], mem_rdata → load_data), is reused by the bench's reference model.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ready on first ACCESS cycle → mem_re=1, mem_be=1111, done at N+2, load_data=0xDEADBEEF.
- LB addr=0x103 and LBU addr=0x103, with rdata=0x80112233 → LB gives load_data=0xFFFFFF80 and LBU gives 0x00000080. LH addr=0x102 → 0xFFFF8011.
- SB addr=0x201, sd=0x000000A5 → mem_we=1, be=0010, wdata=0xA5A5A5A5. SH addr=0x202, sd=0x1234 → be=1100, wdata=0x12341234.
- LW addr=0x102 → no mem_re pulse, done and misaligned in cycle N+2, load_data unchanged. LH with funct3=011 → same fault response.
- mem_ready held low with TIMEOUT=4 → 4 ACCESS cycles, then done with timeout=1. A second req pulsed mid-wait is ignored.
- rst asserted in the 2nd ACCESS cycle → mem_re=0 and busy=0 after that edge. The next req for LW 0x104 completes normally.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared RV32I load/store definitions for the load/store unit.
// Holds funct3 width codes, LOAD/STORE opcodes, the LSU state encoding
// and the request legality check used when a request is accepted.
package riscv_defs;

  // Load width codes
  localparam logic [2:0] L_BYTE   = 3'b000;
  localparam logic [2:0] L_HWORD  = 3'b001;
  localparam logic [2:0] L_WORD   = 3'b010;
  localparam logic [2:0] L_BYTEU  = 3'b100;
  localparam logic [2:0] L_HWORDU = 3'b101;

  // Store width codes
  localparam logic [2:0] S_BYTE  = 3'b000;
  localparam logic [2:0] S_HWORD = 3'b001;
  localparam logic [2:0] S_WORD  = 3'b010;

  // Major opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } lsu_state_e;

  // Illegal width code or an access not aligned to its own size.
  function automatic logic lsu_access_fault(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic illegal;
    logic is_half;
    logic is_word;
    if (is_store) begin
      illegal = (funct3 > S_WORD);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    is_half = (funct3[1:0] == 2'b01);
    is_word = (funct3[1:0] == 2'b10);
    return illegal | (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load result formatter: selects the byte/halfword lane from a memory word
// and sign- or zero-extends it according to funct3.
//   funct3    : RV32I load width code
//   addr_lo   : low two bits of the byte address
//   mem_rdata : raw memory word
//   load_data : aligned and extended result (combinational)
module lsu_load_format
  import riscv_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (addr_lo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = mem_rdata;
    case (funct3)
      L_BYTE:   load_data = {{24{w_byte[7]}}, w_byte};
      L_BYTEU:  load_data = {24'd0, w_byte};
      L_HWORD:  load_data = {{16{w_half[15]}}, w_half};
      L_HWORDU: load_data = {16'd0, w_half};
      default:  load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts a single-cycle request, drives a word-addressed
// memory port with byte enables, waits for mem_ready (bounded by TIMEOUT),
// and returns formatted load data with a one-cycle done pulse.
//   clk, rst                 : clock, synchronous active-high reset
//   req, is_store, funct3,
//   addr, store_data         : request (sampled only in IDLE)
//   mem_addr, mem_re, mem_we,
//   mem_be, mem_wdata        : memory command (registered)
//   mem_rdata, mem_ready     : memory response
//   load_data, done,
//   misaligned, timeout, busy: results and status (registered)
module load_store_unit
  import riscv_defs::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              misaligned,
  output logic              timeout,
  output logic              busy
);

  lsu_state_e        r_state;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_load_data;
  logic              r_done;
  logic              r_misaligned;
  logic              r_timeout;
  logic              r_busy;

  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_fault;
  logic [31:0]       w_fmt_data;

  // Lane steering for the incoming request: byte enables by size/offset,
  // store data replicated across every lane it may land in.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
    if (!is_store) begin
      w_wdata = 32'd0;
    end
    w_fault = lsu_access_fault(is_store, funct3, addr[1:0]);
  end

  lsu_load_format u_fmt (
    .funct3    (r_funct3),
    .addr_lo   (r_addr_lo),
    .mem_rdata (mem_rdata),
    .load_data (w_fmt_data)
  );

  // Control FSM with registered outputs.
  // A fault passes through FAULT for one cycle, so its done pulse lands
  // on the same cycle as a zero-wait successful access would.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'd0;
      r_mem_wdata  <= 32'd0;
      r_load_data  <= 32'd0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (req) begin
            r_is_store   <= is_store;
            r_funct3     <= funct3;
            r_addr_lo    <= addr[1:0];
            r_cnt        <= '0;
            r_mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
            r_mem_be     <= w_be;
            r_mem_wdata  <= w_wdata;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b1;
            if (w_fault) begin
              r_misaligned <= 1'b1;
              r_state      <= ST_FAULT;
            end else begin
              r_misaligned <= 1'b0;
              r_mem_re     <= !is_store;
              r_mem_we     <= is_store;
              r_state      <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          if (mem_ready) begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
            if (!r_is_store) begin
              r_load_data <= w_fmt_data;
            end
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_FAULT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_FAULT: begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;
  assign load_data  = r_load_data;
  assign done       = r_done;
  assign misaligned = r_misaligned;
  assign timeout    = r_timeout;
  assign busy       = r_busy;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] load_data;
  logic        done;
  logic        misaligned;
  logic        timeout;
  logic        busy;

  int checks;
  int failures;

  load_store_unit #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .load_data  (load_data),
    .done       (done),
    .misaligned (misaligned),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse req for exactly one sampling edge; returns #1 after that edge.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    req        = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({done, busy, mem_re, mem_we, misaligned, timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {done, busy, mem_re, mem_we, misaligned, timeout});
    end
    checks++;
    if ({load_data, mem_be, mem_wdata} !== 68'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {load_data, mem_be, mem_wdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw;
    mem_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    checks++;
    if ({mem_re, mem_we, mem_be, busy, done} !== 8'b10_1111_10) begin
      failures++;
      $display("FAIL lw_access got=%b exp=10111110", {mem_re, mem_we, mem_be, busy, done});
    end
    checks++;
    if (mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL lw_addr got=%h exp=00000100", mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    // Request during DONE must be ignored.
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h200; req = 1'b1;
    checks++;
    if ({done, mem_re, load_data} !== {2'b10, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL lw_done got=%b/%h exp=10/deadbeef", {done, mem_re}, load_data);
    end
    tick();
    req = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if ({done, busy, mem_re} !== 3'b000) begin
      failures++;
      $display("FAIL lw_idle_req_ignored got=%b exp=000", {done, busy, mem_re});
    end
    tick();
  endtask

  task automatic test_sub_word_loads;
    logic [2:0]  f3s  [5];
    logic [31:0] adrs [5];
    logic [3:0]  bes  [5];
    logic [31:0] exps [5];
    f3s[0] = 3'b000; adrs[0] = 32'h103; bes[0] = 4'b1000; exps[0] = 32'hFFFFFF80;
    f3s[1] = 3'b100; adrs[1] = 32'h103; bes[1] = 4'b1000; exps[1] = 32'h00000080;
    f3s[2] = 3'b001; adrs[2] = 32'h102; bes[2] = 4'b1100; exps[2] = 32'hFFFF8011;
    f3s[3] = 3'b101; adrs[3] = 32'h100; bes[3] = 4'b0011; exps[3] = 32'h00002233;
    f3s[4] = 3'b000; adrs[4] = 32'h100; bes[4] = 4'b0001; exps[4] = 32'h00000033;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'h0);
      checks++;
      if ({mem_re, mem_be} !== {1'b1, bes[i]}) begin
        failures++;
        $display("FAIL subload_be[%0d] got=%b exp=%b", i, {mem_re, mem_be}, {1'b1, bes[i]});
      end
      mem_ready = 1'b1;
      mem_rdata = 32'h80112233;
      tick();
      mem_ready = 1'b0;
      checks++;
      if ({done, load_data} !== {1'b1, exps[i]}) begin
        failures++;
        $display("FAIL subload_data[%0d] got=%b/%h exp=1/%h", i, done, load_data, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_stores;
    issue(1'b1, 3'b000, 32'h201, 32'h000000A5);
    checks++;
    if ({mem_we, mem_re, mem_be, mem_wdata, mem_addr} !== {2'b10, 4'b0010, 32'hA5A5A5A5, 32'h200}) begin
      failures++;
      $display("FAIL sb got=%b/%b/%h/%h exp=10/0010/a5a5a5a5/00000200", {mem_we, mem_re}, mem_be, mem_wdata, mem_addr);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({done, mem_we, load_data} !== {2'b10, 32'h00000033}) begin
      failures++;
      $display("FAIL sb_done got=%b/%h exp=10/00000033", {done, mem_we}, load_data);
    end
    tick();

    issue(1'b1, 3'b001, 32'h202, 32'h00001234);
    checks++;
    if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b1100, 32'h12341234}) begin
      failures++;
      $display("FAIL sh got=%b/%b/%h exp=1/1100/12341234", mem_we, mem_be, mem_wdata);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();

    // SW with one wait cycle: strobe and payload must hold.
    issue(1'b1, 3'b010, 32'h204, 32'hCAFEF00D);
    tick();
    checks++;
    if ({mem_we, done, mem_be, mem_wdata} !== {2'b10, 4'b1111, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL sw_wait got=%b/%b/%h exp=10/1111/cafef00d", {mem_we, done}, mem_be, mem_wdata);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({done, mem_we} !== 2'b10) begin
      failures++;
      $display("FAIL sw_done got=%b exp=10", {done, mem_we});
    end
    tick();
  endtask

  task automatic test_faults;
    logic [2:0]  f3s [3];
    logic [31:0] ads [3];
    logic        sts [3];
    f3s[0] = 3'b010; ads[0] = 32'h102; sts[0] = 1'b0;
    f3s[1] = 3'b011; ads[1] = 32'h100; sts[1] = 1'b0;
    f3s[2] = 3'b100; ads[2] = 32'h100; sts[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(sts[i], f3s[i], ads[i], 32'h55);
      mem_ready = 1'b1;
      checks++;
      if ({mem_re, mem_we, done, busy} !== 4'b0001) begin
        failures++;
        $display("FAIL fault_n1[%0d] got=%b exp=0001", i, {mem_re, mem_we, done, busy});
      end
      tick();
      mem_ready = 1'b0;
      checks++;
      if ({done, misaligned, timeout, mem_re, mem_we, load_data} !== {5'b11000, 32'h00000033}) begin
        failures++;
        $display("FAIL fault_done[%0d] got=%b/%h exp=11000/00000033", i,
                 {done, misaligned, timeout, mem_re, mem_we}, load_data);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_timeout;
    int  re_cycles;
    bit  seen;
    mem_ready = 1'b0;
    re_cycles = 0;
    seen      = 1'b0;
    issue(1'b0, 3'b010, 32'h108, 32'h0);
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mem_re) re_cycles++;
      // Second request mid-wait must be ignored.
      req  = (c == 1);
      addr = 32'h300;
      tick();
    end
    req = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL timeout_no_done got=0 exp=1");
    end
    checks++;
    if (re_cycles != 4) begin
      failures++;
      $display("FAIL timeout_access_cycles got=%0d exp=4", re_cycles);
    end
    checks++;
    if ({timeout, misaligned, load_data} !== {2'b10, 32'h00000033}) begin
      failures++;
      $display("FAIL timeout_flags got=%b/%h exp=10/00000033", {timeout, misaligned}, load_data);
    end
    tick();
    tick();
    checks++;
    if ({busy, mem_re, done} !== 3'b000) begin
      failures++;
      $display("FAIL timeout_ignored_req got=%b exp=000", {busy, mem_re, done});
    end
    // Next accepted request clears the sticky fault flag.
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    checks++;
    if ({timeout, mem_re} !== 2'b01) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=01", {timeout, mem_re});
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h0000ABCD;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access;
    mem_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10C, 32'h0);
    tick();
    rst = 1'b1;
    checks++;
    if (mem_re !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=1", mem_re);
    end
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_re, busy, done, load_data} !== 35'd0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%h exp=000/00000000", {mem_re, busy, done}, load_data);
    end
    tick();
    issue(1'b0, 3'b010, 32'h104, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h01234567;
    checks++;
    if ({mem_re, mem_addr} !== {1'b1, 32'h104}) begin
      failures++;
      $display("FAIL rst_next_access got=%b/%h exp=1/00000104", mem_re, mem_addr);
    end
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({done, load_data} !== {1'b1, 32'h01234567}) begin
      failures++;
      $display("FAIL rst_next_done got=%b/%h exp=1/01234567", done, load_data);
    end
    tick();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req        = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'd0;
    addr       = 32'd0;
    store_data = 32'd0;
    mem_rdata  = 32'd0;
    mem_ready  = 1'b0;
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
